// File: rtl/expr_stmt_fsm.sv
// Byte-serial recogniser for `LHS = expr ;` statements with nested parentheses,
// error resynchronisation on `;` and a wrapping accepted-statement counter.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// LHS_START  | expecting first letter of the assignment target
// LHS_ID     | inside the target identifier
// LHS_END    | target finished by space, expecting `=`
// RHS_START  | expecting an operand or `(`
// IN_OPND    | inside an operand token (num: token is numeric)
// AFTER_OPND | operand or `)` finished, expecting operator, `)` or `;`
// ERR        | statement in error, skipping to next `;`
module expr_stmt_fsm #(
   parameter int MAX_DEPTH  = 4,
   parameter int CNT_W      = 8,
   parameter int MULTI_CHAR = 1
) (
   input  logic             clk,
   input  logic             clr,
   input  logic [7:0]       in,
   input  logic             in_valid,
   output logic             out,
   output logic             err,
   output logic [3:0]       depth,
   output logic [CNT_W-1:0] stmt_cnt
);

   typedef enum logic [2:0] {
      LHS_START, LHS_ID, LHS_END, RHS_START, IN_OPND, AFTER_OPND, ERR
   } state_t;

   localparam logic [3:0] MAXD = 4'(MAX_DEPTH);
   localparam logic       MC   = (MULTI_CHAR != 0);

   state_t     state, state_nxt;
   logic       num, num_nxt;
   logic [3:0] depth_nxt;
   logic       cnt_inc;
   logic       out_nxt, err_nxt;

   logic is_l, is_d, is_op, is_sp, is_eq, is_lp, is_rp, is_semi, is_legal;

   always_comb begin
      is_l     = (in >= 8'h61 && in <= 8'h7a) || (in >= 8'h41 && in <= 8'h5a);
      is_d     = (in >= 8'h30 && in <= 8'h39);
      is_op    = (in == 8'h2b) || (in == 8'h2d) || (in == 8'h2a) || (in == 8'h2f);
      is_sp    = (in == 8'h20);
      is_eq    = (in == 8'h3d);
      is_lp    = (in == 8'h28);
      is_rp    = (in == 8'h29);
      is_semi  = (in == 8'h3b);
      is_legal = is_l | is_d | is_op | is_sp | is_eq | is_lp | is_rp | is_semi;
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state    <= LHS_START;
         num      <= 1'b0;
         depth    <= '0;
         stmt_cnt <= '0;
         out      <= 1'b0;
         err      <= 1'b0;
      end else if (in_valid) begin
         state    <= state_nxt;
         num      <= num_nxt;
         depth    <= depth_nxt;
         stmt_cnt <= stmt_cnt + CNT_W'(cnt_inc);
         out      <= out_nxt;
         err      <= err_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      num_nxt   = num;
      depth_nxt = depth;
      cnt_inc   = 1'b0;
      if (state != ERR && !is_legal) begin
         state_nxt = ERR;
      end else begin
         case (state)
            LHS_START: begin
               if (is_l)        state_nxt = LHS_ID;
               else if (!is_sp) state_nxt = ERR;
            end
            LHS_ID: begin
               if (is_l || is_d) state_nxt = MC ? LHS_ID : ERR;
               else if (is_sp)   state_nxt = LHS_END;
               else if (is_eq)   state_nxt = RHS_START;
               else              state_nxt = ERR;
            end
            LHS_END: begin
               if (is_eq)       state_nxt = RHS_START;
               else if (!is_sp) state_nxt = ERR;
            end
            RHS_START: begin
               if (is_l || is_d) begin
                  state_nxt = IN_OPND;
                  num_nxt   = is_d;
               end else if (is_lp) begin
                  if (depth == MAXD) state_nxt = ERR;
                  else               depth_nxt = depth + 4'd1;
               end else if (!is_sp) begin
                  state_nxt = ERR;
               end
            end
            IN_OPND, AFTER_OPND: begin
               if (is_rp) begin
                  if (depth == 4'd0) state_nxt = ERR;
                  else begin
                     state_nxt = AFTER_OPND;
                     depth_nxt = depth - 4'd1;
                  end
               end else if (is_semi) begin
                  if (depth == 4'd0) begin
                     state_nxt = LHS_START;
                     cnt_inc   = 1'b1;
                  end else begin
                     state_nxt = ERR;
                  end
               end else if (is_op) begin
                  state_nxt = RHS_START;
               end else if (is_sp) begin
                  state_nxt = AFTER_OPND;
               end else if (state == IN_OPND && is_d) begin
                  state_nxt = MC ? IN_OPND : ERR;
               end else if (state == IN_OPND && is_l) begin
                  state_nxt = (MC && !num) ? IN_OPND : ERR;
               end else begin
                  state_nxt = ERR;
               end
            end
            default: begin
               // ERR: resynchronise on the next terminator
               if (is_semi) begin
                  state_nxt = LHS_START;
                  depth_nxt = '0;
               end
            end
         endcase
      end
   end

   always_comb begin
      out_nxt = (state_nxt == IN_OPND || state_nxt == AFTER_OPND) && (depth_nxt == 4'd0);
      err_nxt = (state_nxt == ERR);
   end

endmodule

// File: tb/tb_expr_stmt_fsm.sv
// Bench for expr_stmt_fsm: three parameterisations share one character stream
// and are compared every edge against a grammar-level reference model.
module tb_expr_stmt_fsm;

   logic       clk = 1'b0;
   logic       clr;
   logic       in_valid;
   logic [7:0] in;

   always #5 clk = ~clk;

   logic       o0, e0, o1, e1, o2, e2;
   logic [3:0] d0, d1, d2;
   logic [7:0] c0, c2;
   logic [1:0] c1;

   expr_stmt_fsm #(.MAX_DEPTH(4), .CNT_W(8), .MULTI_CHAR(1)) u_def (
      .clk(clk), .clr(clr), .in(in), .in_valid(in_valid),
      .out(o0), .err(e0), .depth(d0), .stmt_cnt(c0));
   expr_stmt_fsm #(.MAX_DEPTH(2), .CNT_W(2), .MULTI_CHAR(1)) u_d2 (
      .clk(clk), .clr(clr), .in(in), .in_valid(in_valid),
      .out(o1), .err(e1), .depth(d1), .stmt_cnt(c1));
   expr_stmt_fsm #(.MAX_DEPTH(4), .CNT_W(8), .MULTI_CHAR(0)) u_mc0 (
      .clk(clk), .clr(clr), .in(in), .in_valid(in_valid),
      .out(o2), .err(e2), .depth(d2), .stmt_cnt(c2));

   localparam int MXD[3] = '{4, 2, 4};
   localparam int CW[3]  = '{8, 2, 8};
   localparam int MCH[3] = '{1, 1, 0};

   // reference phases of the statement grammar
   localparam int PH_LHS0 = 0, PH_NAME = 1, PH_PRE_EQ = 2, PH_WANT = 3,
                  PH_TOK = 4, PH_POST = 5, PH_BAD = 6;

   int n_cmp = 0;
   int n_bad = 0;
   int m_ph[3], m_dep[3], m_num[3], m_cnt[3];

   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic bit c_l(input logic [7:0] c);
      return (c >= "a" && c <= "z") || (c >= "A" && c <= "Z");
   endfunction
   function automatic bit c_d(input logic [7:0] c);
      return c >= "0" && c <= "9";
   endfunction
   function automatic bit c_op(input logic [7:0] c);
      return c == "+" || c == "-" || c == "*" || c == "/";
   endfunction
   function automatic bit c_ok(input logic [7:0] c);
      return c_l(c) || c_d(c) || c_op(c) || c == " " || c == "=" ||
             c == "(" || c == ")" || c == ";";
   endfunction

   task automatic mdl_reset();
      for (int k = 0; k < 3; k++) begin
         m_ph[k] = PH_LHS0; m_dep[k] = 0; m_num[k] = 0; m_cnt[k] = 0;
      end
   endtask

   task automatic mdl_char(input int k, input logic [7:0] c);
      int ph, d;
      ph = m_ph[k];
      d  = m_dep[k];
      if (ph == PH_BAD) begin
         if (c == ";") begin ph = PH_LHS0; d = 0; end
      end else if (!c_ok(c)) begin
         ph = PH_BAD;
      end else if (ph == PH_LHS0) begin
         if (c_l(c)) ph = PH_NAME;
         else if (c != " ") ph = PH_BAD;
      end else if (ph == PH_NAME) begin
         if (c_l(c) || c_d(c)) ph = MCH[k] ? PH_NAME : PH_BAD;
         else if (c == " ") ph = PH_PRE_EQ;
         else if (c == "=") ph = PH_WANT;
         else ph = PH_BAD;
      end else if (ph == PH_PRE_EQ) begin
         if (c == "=") ph = PH_WANT;
         else if (c != " ") ph = PH_BAD;
      end else if (ph == PH_WANT) begin
         if (c_l(c) || c_d(c)) begin ph = PH_TOK; m_num[k] = c_d(c); end
         else if (c == "(") begin
            if (d < MXD[k]) d++; else ph = PH_BAD;
         end else if (c != " ") ph = PH_BAD;
      end else begin
         // inside or just after an operand
         if (c == ")") begin
            if (d == 0) ph = PH_BAD; else begin d--; ph = PH_POST; end
         end else if (c == ";") begin
            if (d == 0) begin ph = PH_LHS0; m_cnt[k] = (m_cnt[k] + 1) % (1 << CW[k]); end
            else ph = PH_BAD;
         end else if (c_op(c)) ph = PH_WANT;
         else if (c == " ") ph = PH_POST;
         else if (ph == PH_TOK && c_d(c)) ph = MCH[k] ? PH_TOK : PH_BAD;
         else if (ph == PH_TOK && c_l(c)) ph = (MCH[k] && m_num[k] == 0) ? PH_TOK : PH_BAD;
         else ph = PH_BAD;
      end
      m_ph[k]  = ph;
      m_dep[k] = d;
   endtask

   task automatic check_all(input string tag);
      int o, e, d, c;
      for (int k = 0; k < 3; k++) begin
         case (k)
            0:       begin o = o0; e = e0; d = d0; c = c0; end
            1:       begin o = o1; e = e1; d = d1; c = c1; end
            default: begin o = o2; e = e2; d = d2; c = c2; end
         endcase
         chk($sformatf("%s dut%0d out", tag, k), o,
             int'((m_ph[k] == PH_TOK || m_ph[k] == PH_POST) && m_dep[k] == 0));
         chk($sformatf("%s dut%0d err", tag, k), e, int'(m_ph[k] == PH_BAD));
         chk($sformatf("%s dut%0d depth", tag, k), d, m_dep[k]);
         chk($sformatf("%s dut%0d cnt", tag, k), c, m_cnt[k]);
      end
   endtask

   task automatic step(input logic [7:0] c, input logic v, input logic r, input string tag);
      @(negedge clk);
      in = c; in_valid = v; clr = r;
      @(posedge clk);
      #1;
      if (r) mdl_reset();
      else if (v) for (int k = 0; k < 3; k++) mdl_char(k, c);
      check_all(tag);
   endtask

   task automatic send_str(input string s, input string tag);
      for (int i = 0; i < s.len(); i++) step(s[i], 1'b1, 1'b0, tag);
   endtask

   task automatic do_clr();
      step(8'h00, 1'b0, 1'b1, "clr");
   endtask

   initial begin
      string alpha;
      logic [7:0] ch;
      clr = 1'b1; in_valid = 1'b0; in = 8'h00;
      mdl_reset();

      do_clr();
      chk("reset out", o0, 0);
      chk("reset err", e0, 0);
      chk("reset depth", d0, 0);
      chk("reset cnt", c0, 0);

      send_str("a=b+c;", "simple");
      chk("simple cnt", c0, 1);
      chk("simple err", e0, 0);

      do_clr();
      send_str("x1 = (a + 12) * b3 ", "paren");
      chk("paren out before semi", o0, 1);
      send_str(";", "paren");
      chk("paren out after semi", o0, 0);
      chk("paren cnt", c0, 1);

      do_clr();
      send_str("y=(((a", "deep");
      chk("deep d2 err", e1, 1);
      chk("deep def err", e0, 0);
      send_str(";", "deep");
      chk("deep d2 resync", e1, 0);
      send_str("q=1;", "deep");
      chk("deep d2 cnt", c1, 1);

      do_clr(); send_str("a=12b", "e1"); chk("a=12b err", e0, 1);
      do_clr(); send_str("a=b)", "e2");  chk("a=b) err", e0, 1);
      do_clr(); send_str("a=b+;", "e3"); chk("a=b+; err", e0, 1); chk("a=b+; cnt", c0, 0);
      do_clr(); send_str("=a", "e4");    chk("=a err", e0, 1);

      do_clr(); send_str("ab", "mc0");   chk("mc0 ab err", e2, 1);
      do_clr(); send_str("a=b*c;", "mc0"); chk("mc0 cnt", c2, 1);

      do_clr();
      send_str("a", "hold");
      repeat (3) step(8'($urandom), 1'b0, 1'b0, "hold");
      send_str("=", "hold");
      repeat (3) step(8'($urandom), 1'b0, 1'b0, "hold");
      send_str("b", "hold");
      chk("hold out", o0, 1);

      do_clr();
      send_str("a=(b", "clrmid");
      step(8'h3b, 1'b1, 1'b1, "clrmid");
      chk("clrmid depth", d0, 0);
      chk("clrmid out", o0, 0);
      chk("clrmid cnt", c0, 0);

      do_clr();
      repeat (5) send_str("a=b;", "wrap");
      chk("wrap cnt", c1, 1);

      do_clr();
      alpha = "abzXY0199+-*/  ==(()));;;;";
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 99) < 3) ch = 8'($urandom_range(0, 255));
         else ch = alpha[$urandom_range(0, alpha.len() - 1)];
         step(ch, ($urandom_range(0, 99) < 85), ($urandom_range(0, 199) == 0), "rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/expr_stmt_fsm.md
Name: expr_stmt_fsm

Overview:
- Byte-serial recogniser for assignment statements of the form `LHS = expr ;`, one ASCII character per accepted cycle.
- Generalises the single-character "operand op operand" matcher:
  - multi-character identifiers and numbers
  - nested parentheses up to a parametrised depth
  - `;`-terminated statements with error resynchronisation
  - an accepted-statement counter
- Sits after the character source in the lab datapath; `out` flags "the text since the last `;` is a complete valid statement body".

Parameters:
- MAX_DEPTH, 4, maximum parenthesis nesting depth (1..15).
- CNT_W, 8, width of the accepted-statement counter.
- MULTI_CHAR, 1, 1 = operands may be multi-character tokens; 0 = every operand is exactly one character.

Ports:
- clk  input  1  clock, rising edge.
- clr  input  1  synchronous active-high reset.
- in  input  8  ASCII character.
- in_valid  input  1  `in` is consumed on this edge only when 1.
- out  output  1  registered: the current statement body is complete and valid.
- err  output  1  registered: the current statement is in error.
- depth  output  4  current open-parenthesis count.
- stmt_cnt  output  CNT_W  number of statements accepted with `;`.

Behaviour:
- Reset and hold:
  - `clr` is sampled on posedge clk and has priority over `in_valid`.
  - Reset values: state = LHS_START, out = 0, err = 0, depth = 0, stmt_cnt = 0.
  - `clr` mid-statement discards that statement.
  - `in_valid` = 0: every register holds.
- Character classes:
  - L = a-z, A-Z; D = 0-9; OP = `+ - * /`; SP = space.
  - Also `=`, `(`, `)`, `;`.
  - Any other byte is illegal and goes to ERR from every non-ERR state.
- States (SP is a self-loop unless stated otherwise):
  - LHS_START:
    - L -> LHS_ID
    - anything else -> ERR
  - LHS_ID:
    - L/D -> LHS_ID, only if MULTI_CHAR=1; with MULTI_CHAR=0 -> ERR
    - SP -> LHS_END
    - `=` -> RHS_START
    - else -> ERR
  - LHS_END:
    - `=` -> RHS_START
    - else -> ERR
  - RHS_START (expecting an operand):
    - L -> IN_OPND with num = 0
    - D -> IN_OPND with num = 1
    - `(` -> RHS_START, depth + 1
    - `(` when depth == MAX_DEPTH -> ERR
    - else -> ERR
  - IN_OPND:
    - D -> IN_OPND (MULTI_CHAR=1 only)
    - L -> IN_OPND if num = 0 and MULTI_CHAR=1; if num = 1 -> ERR
    - With MULTI_CHAR=0, any L or D -> ERR.
    - SP -> AFTER_OPND
    - OP -> RHS_START
    - `)` -> AFTER_OPND, depth - 1
    - `;` -> see terminator rule
    - else -> ERR
  - AFTER_OPND:
    - OP -> RHS_START
    - `)` -> AFTER_OPND, depth - 1
    - `;` -> see terminator rule
    - L/D/`(`/`=` -> ERR
  - `)` with depth == 0 -> ERR, in both IN_OPND and AFTER_OPND.
- Terminator rule:
  - `;` in IN_OPND or AFTER_OPND with depth == 0 -> LHS_START, stmt_cnt + 1 (wraps modulo 2^CNT_W).
  - `;` in any other non-ERR state -> ERR.
- ERR:
  - `;` -> LHS_START with depth cleared; stmt_cnt unchanged.
  - All other bytes are ignored.
- Outputs are registered from the next state, so they are valid the cycle after the consuming edge:
  - out = 1 iff next state is IN_OPND or AFTER_OPND and next depth == 0.
  - err = 1 iff next state is ERR.
  - out and err are never both 1.
- Entering LHS_START (via `;` or `clr`) clears depth to 0.
- Latency: 1 cycle per character; no backpressure.

Test Plan:
- `a=b+c;` with in_valid=1 each cycle -> out after each byte 0,0,1,0,1,0; err stays 0; stmt_cnt = 1.
- `x1 = (a + 12) * b3 ;` -> depth reads 1 after `(`, 0 after `)`; out = 1 after `)`, `3` and trailing SP; out = 0 after the final `;`; stmt_cnt = 1.
- MAX_DEPTH=2, `y=(((a` -> err = 1 after the third `(`; then `;q=1;` -> err = 0 after the first `;`, stmt_cnt = 1 after the final `;`.
- Error cases:
  - `a=12b` -> err = 1 after `b`.
  - `a=b)` -> err = 1 after `)`.
  - `a=b+;` -> err = 1 after `;`, stmt_cnt unchanged.
  - `=a` -> err = 1 after `=`.
- MULTI_CHAR=0: `ab=c;` -> err = 1 after `b`; `a=b*c;` -> accepted, stmt_cnt = 1.
- Hold, reset and wrap:
  - `a=b` with in_valid low for 3 cycles between bytes -> outputs hold; out = 1 after `b`.
  - `clr` pulse after `a=(b` -> depth = 0, out = 0, stmt_cnt = 0 on the next cycle.
  - CNT_W=2 with 5 valid statements -> stmt_cnt = 1.
